rr_arbiter: RTL and testbench
=============================

# rr_arbiter

Parametrised N-way round-robin arbiter with registered one-hot grant. It is the multi-requester successor of the single-channel registered req/gnt responder. It sits between N bus masters and one shared target. It samples requests on each rising clock edge and drives a one-cycle-latency grant. An optional grant-hold mode keeps ownership across multi-cycle transfers, with a bounded tenure.

## Interface
- `N`, default 4: number of requesters; legal range 2..32.
- `MAX_HOLD`, default 8: maximum consecutive grant cycles per tenure in hold mode; legal range 1..255. Ignored when hold mode is compiled out.
- `clk` input 1: sole clock; all state updates on the rising edge.
- `rst_n` input 1: synchronous reset, active low.
- `req` input N: request vector; bit i belongs to requester i.
- `gnt` output N: registered one-hot grant, or all zeros.
- `gnt_vld` output 1: registered; high exactly when `gnt` is non-zero.
- `gnt_id` output $clog2(N): registered binary index of the granted requester; 0 when `gnt_vld` is low.

## Operation
- State register `st` has two states: IDLE and BUSY. Also held: rotating pointer `ptr` ($clog2(N) bits), owner index `own`, and tenure counter `hcnt` ($clog2(MAX_HOLD+1) bits).
- Pick function: starting at `ptr`, scan upward modulo N and select the first i with `req[i]=1`. Index N-1 wraps to 0.
- IDLE:
  - `req==0`: stay IDLE; `gnt=0`.
  - Otherwise: grant the pick, go to BUSY, set `own`=pick, `ptr`=(pick+1) mod N, `hcnt`=1.
- BUSY, hold mode:
  - `req[own]=1` and `hcnt<MAX_HOLD`: keep the grant and increment `hcnt`.
  - Any other case is a release: re-run pick with the updated `ptr`.
    - If a requester is found, grant it in the same edge (no idle gap), restart `hcnt`=1, and advance `ptr`.
    - If none is found, go to IDLE and drive `gnt=0`.
  - If the owner is the only requester at tenure expiry, the pick returns the owner again. It is re-granted with `hcnt`=1.
- BUSY, no hold mode: re-arbitrate on every edge, exactly as from IDLE. Each grant lasts one cycle unless the same requester wins again.
- `req` bits that drop while not granted have no effect. Requests are level-sensitive and not latched.
- Fairness bound: with all N requesting, any requester waits at most (N-1)·MAX_HOLD cycles in hold mode, or N-1 cycles without it.

## Timing
- Latency: `req` sampled at edge k appears on `gnt`/`gnt_id`/`gnt_vld` after edge k. This is one cycle, and there is no combinational path from `req` to the outputs.
- Reset: when `rst_n=0` at a rising edge, the following clear at that edge regardless of `req`:
  - `gnt=0`, `gnt_vld=0`, `gnt_id=0`
  - `st`=IDLE, `ptr=0`, `own=0`, `hcnt=0`
- Reset mid-tenure aborts the grant; the first grant after reset starts its search from index 0.
- First arbitration uses the first edge with `rst_n=1`; the grant is visible after that edge.
- Owner drop and new request in the same cycle: the grant moves in one edge.
- Simultaneous owner drop and tenure expiry: treated as a single release.

## Configuration
- Macro `RR_ARBITER_HOLD_EN`:
  - Defined: hold mode as described, with `MAX_HOLD` bounding each tenure.
  - Undefined: the `hcnt` register and hold logic are not built, `MAX_HOLD` is unused, and a fresh round-robin pick is made every cycle.

## Structure
- Package `arb_pkg` contains:
  - `typedef enum logic {ARB_IDLE, ARB_BUSY} arb_st_t`
  - localparam helper for index width
  - constant `ARB_MAX_N = 32`
- Sub-module `rr_pick`: purely combinational rotated priority search.
  - Inputs: `req[N]`, `ptr`.
  - Outputs: `found`, `idx`, `onehot`.
  - Instantiated once; all state stays in `rr_arbiter`.

## Test plan
All scenarios use N=4, MAX_HOLD=4.
- Reset: hold `rst_n=0` for 2 cycles with `req=4'b1111` → `gnt=0`, `gnt_vld=0`, `gnt_id=0` on both cycles.
- Single request: `req=4'b0100` sampled at edge k → after k, `gnt=4'b0100`, `gnt_id=2`, `gnt_vld=1`; `req=0` at edge k+1 → `gnt=0` after k+1.
- No hold, `req=4'b1111` steady → `gnt` sequence `0001, 0010, 0100, 1000, 0001`; `gnt_id` sequence 0,1,2,3,0.
- Hold, `req=4'b1111` steady → `0001` for 4 cycles, then `0010` for 4 cycles, then `0100`; no gap cycles. With only `req=4'b1000` steady → `1000` continuously.
- Hold, owner drop: requester 0 granted, then `req` changes to `4'b0010` → `gnt=0010` after the next edge, `hcnt` restarts; then `req=0` → `gnt=0`, state IDLE.
- Reset mid-tenure: requester 2 granted, `rst_n=0` for one edge → `gnt=0`; release with `req=4'b1111` → first grant is `0001`.

Source files
------------

// File: rtl/rr_arbiter_pkg.sv
// Shared types and constants for the round-robin arbiter.
//   arb_st_t   : arbiter state encoding (idle / busy)
//   arb_idx_w  : width of a binary requester index for n requesters
//   ARB_MAX_N  : largest supported requester count
package arb_pkg;

   typedef enum logic {ARB_IDLE, ARB_BUSY} arb_st_t;

   localparam int ARB_MAX_N = 32;

   // Keep the index at least one bit wide so N=2 still gets a real vector.
   function automatic int arb_idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_arbiter_if.sv
// Request/grant bundle between N bus masters and the arbiter.
//   req     : per-requester request levels (master -> arbiter)
//   gnt     : one-hot grant, or all zeros (arbiter -> master)
//   gnt_vld : high when gnt is non-zero
//   gnt_id  : binary index of the granted requester, 0 when idle
// Modports: master (request side), slave (arbiter side).
interface rr_arbiter_if
   import arb_pkg::*;
#(
   parameter int N = 4
);
   localparam int IW = arb_idx_w(N);

   logic [N-1:0]  req;
   logic [N-1:0]  gnt;
   logic          gnt_vld;
   logic [IW-1:0] gnt_id;

   modport master (output req, input gnt, input gnt_vld, input gnt_id);
   modport slave  (input req, output gnt, output gnt_vld, output gnt_id);

endinterface

// File: rtl/rr_arbiter_pick.sv
// Combinational rotated-priority search used by rr_arbiter.
//   req_i    : request vector
//   ptr_i    : index where the search starts (scans upward, wraps N-1 -> 0)
//   found_o  : at least one request set
//   idx_o    : binary index of the selected requester (0 when none)
//   onehot_o : one-hot form of idx_o (0 when none)
module rr_pick
   import arb_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = arb_idx_w(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic          found_o,
   output logic [IW-1:0] idx_o,
   output logic [N-1:0]  onehot_o
);

   logic [2*N-1:0] req_dbl;
   logic [N-1:0]   req_rot;
   logic [IW:0]    idx_sum;

   // Doubling the vector turns the modulo-N rotation into a plain shift.
   assign req_dbl = {req_i, req_i};
   assign req_rot = req_dbl[N-1:0] | '0;

   always_comb begin
      found_o  = 1'b0;
      idx_o    = '0;
      idx_sum  = '0;
      for (int k = 0; k < N; k++) begin
         if (!found_o && req_dbl[k + int'(ptr_i)]) begin
            found_o = 1'b1;
            idx_sum = {1'b0, ptr_i} + (IW+1)'(k);
            if (idx_sum >= (IW+1)'(N)) begin
               idx_sum = idx_sum - (IW+1)'(N);
            end
            idx_o = idx_sum[IW-1:0];
         end
      end
      onehot_o = found_o ? (N'(1) << idx_o) : '0;
   end

   logic unused_rot;
   assign unused_rot = ^req_rot;

endmodule

// File: rtl/rr_arbiter.sv
// N-way round-robin arbiter with registered one-hot grant.
//   clk   : clock, all state on the rising edge
//   rst_n : synchronous active-low reset
//   bus   : rr_arbiter_if.slave (req in; gnt, gnt_vld, gnt_id out)
// Build option RR_ARBITER_HOLD_EN: when defined, the owner keeps the grant
// while it requests, for at most MAX_HOLD consecutive cycles per tenure.
// When undefined, a fresh round-robin pick is made on every edge.
//
// state    | meaning
// ARB_IDLE | no grant outstanding
// ARB_BUSY | one requester owns the grant (own_q)
module rr_arbiter
   import arb_pkg::*;
#(
   parameter int N        = 4,
   parameter int MAX_HOLD = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   rr_arbiter_if.slave   bus
);

   localparam int IW = arb_idx_w(N);

   if (N < 2 || N > ARB_MAX_N) begin : g_bad_n
      $error("rr_arbiter: N out of range");
   end
   if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
      $error("rr_arbiter: MAX_HOLD out of range");
   end

   arb_st_t       st_q, st_d;
   logic [IW-1:0] ptr_q, ptr_d;
   logic [IW-1:0] own_q, own_d;
   logic [N-1:0]  gnt_q, gnt_d;
   logic          vld_q, vld_d;
   logic [IW-1:0] id_q, id_d;
`ifdef RR_ARBITER_HOLD_EN
   localparam int HW = $clog2(MAX_HOLD + 1);
   logic [HW-1:0] hcnt_q, hcnt_d;
`endif

   logic          pick_found;
   logic [IW-1:0] pick_idx;
   logic [N-1:0]  pick_onehot;

   rr_pick #(.N(N), .IW(IW)) u_pick (
      .req_i    (bus.req),
      .ptr_i    (ptr_q),
      .found_o  (pick_found),
      .idx_o    (pick_idx),
      .onehot_o (pick_onehot)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st_q   <= ARB_IDLE;
         ptr_q  <= '0;
         own_q  <= '0;
         gnt_q  <= '0;
         vld_q  <= 1'b0;
         id_q   <= '0;
`ifdef RR_ARBITER_HOLD_EN
         hcnt_q <= '0;
`endif
      end else begin
         st_q   <= st_d;
         ptr_q  <= ptr_d;
         own_q  <= own_d;
         gnt_q  <= gnt_d;
         vld_q  <= vld_d;
         id_q   <= id_d;
`ifdef RR_ARBITER_HOLD_EN
         hcnt_q <= hcnt_d;
`endif
      end
   end

   always_comb begin
      st_d   = st_q;
      ptr_d  = ptr_q;
      own_d  = own_q;
      gnt_d  = gnt_q;
      vld_d  = vld_q;
      id_d   = id_q;
`ifdef RR_ARBITER_HOLD_EN
      hcnt_d = hcnt_q;
      // Owner still asking with tenure left: keep everything, count on.
      if (st_q == ARB_BUSY && bus.req[own_q] && (hcnt_q < HW'(MAX_HOLD))) begin
         hcnt_d = hcnt_q + HW'(1);
      end else
`endif
      // Idle, or a release from busy: both resolve through the same pick,
      // so a release with other requesters pending has no idle gap.
      if (pick_found) begin
         st_d  = ARB_BUSY;
         own_d = pick_idx;
         ptr_d = (pick_idx == IW'(N - 1)) ? '0 : pick_idx + IW'(1);
         gnt_d = pick_onehot;
         vld_d = 1'b1;
         id_d  = pick_idx;
`ifdef RR_ARBITER_HOLD_EN
         hcnt_d = HW'(1);
`endif
      end else begin
         st_d  = ARB_IDLE;
         gnt_d = '0;
         vld_d = 1'b0;
         id_d  = '0;
`ifdef RR_ARBITER_HOLD_EN
         hcnt_d = '0;
`endif
      end
   end

   assign bus.gnt     = gnt_q;
   assign bus.gnt_vld = vld_q;
   assign bus.gnt_id  = id_q;

endmodule

// File: tb/tb_rr_arbiter.sv
module tb_rr_arbiter;

   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_fail;

   rr_arbiter_if #(.N(4)) bus ();

   rr_arbiter #(.N(4), .MAX_HOLD(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_chk++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   // Advance past the next rising edge; outputs are then stable for checking.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic [3:0] g, input logic [1:0] id);
      chk({tag, ".gnt"}, 32'(bus.gnt), 32'(g));
      chk({tag, ".id"},  32'(bus.gnt_id), 32'(id));
      chk({tag, ".vld"}, 32'(bus.gnt_vld), 32'(g != 4'b0));
   endtask

   logic [3:0] rr_seq [5];
   logic [1:0] rr_ids [5];

   initial begin
      n_chk  = 0;
      n_fail = 0;
      rr_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      rr_ids = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

      // Reset with all requesting: outputs stay cleared.
      rst_n   = 1'b0;
      bus.req = 4'b1111;
      step();
      chk_out("rst0", 4'b0000, 2'd0);
      step();
      chk_out("rst1", 4'b0000, 2'd0);

      // Single request, one-cycle latency, no combinational path.
      rst_n   = 1'b1;
      bus.req = 4'b0100;
      #2;
      chk("lat_pre", 32'(bus.gnt), 32'd0);
      step();
      chk_out("single", 4'b0100, 2'd2);
      bus.req = 4'b0000;
      step();
      chk_out("single_drop", 4'b0000, 2'd0);

      // Reset so the steady rotation starts from index 0.
      rst_n = 1'b0;
      step();
      rst_n   = 1'b1;
      bus.req = 4'b1111;
`ifdef RR_ARBITER_HOLD_EN
      for (int i = 0; i < 4; i++) begin
         step();
         chk_out($sformatf("hold0_%0d", i), 4'b0001, 2'd0);
      end
      for (int i = 0; i < 4; i++) begin
         step();
         chk_out($sformatf("hold1_%0d", i), 4'b0010, 2'd1);
      end
      step();
      chk_out("hold2", 4'b0100, 2'd2);
`else
      for (int i = 0; i < 5; i++) begin
         step();
         chk_out($sformatf("rr_%0d", i), rr_seq[i], rr_ids[i]);
      end
      // Pointer is now 1: sparse requests skip the idle slots.
      bus.req = 4'b1010;
      step();
      chk_out("skip0", 4'b0010, 2'd1);
      step();
      chk_out("skip1", 4'b1000, 2'd3);
      step();
      chk_out("skip2", 4'b0010, 2'd1);
`endif

      // Lone requester keeps winning, including across tenure expiry.
      bus.req = 4'b1000;
      for (int i = 0; i < 10; i++) begin
         step();
         chk_out($sformatf("lone_%0d", i), 4'b1000, 2'd3);
      end

      // Owner drop with a new request: grant moves in one edge, then idle.
      rst_n = 1'b0;
      step();
      rst_n   = 1'b1;
      bus.req = 4'b0001;
      step();
      chk_out("own0", 4'b0001, 2'd0);
      bus.req = 4'b0010;
      step();
      chk_out("own_move", 4'b0010, 2'd1);
      bus.req = 4'b0000;
      step();
      chk_out("own_idle", 4'b0000, 2'd0);

      // Reset mid-tenure aborts the grant; search restarts at index 0.
      bus.req = 4'b0100;
      step();
      chk_out("mid_gnt", 4'b0100, 2'd2);
      rst_n = 1'b0;
      step();
      chk_out("mid_rst", 4'b0000, 2'd0);
      rst_n   = 1'b1;
      bus.req = 4'b1111;
      step();
      chk_out("mid_first", 4'b0001, 2'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
